mcu_phase_sequencer: RTL

Control state machine for the 8051 CPU core. It fetches opcode bytes from program ROM, holds them in an instruction register that drives the instruction decoder, and samples the decoder's next-status code. It then sequences the requested RAM read, ROM operand read, ALU process or RAM write phase through req/ack handshakes. It owns the program counter and the run-phase counter that is fed back to the decoder.

---
 rtl/mcu_phase_sequencer_if.sv | 36 +++
 rtl/mcu_phase_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mcu_phase_sequencer_if.sv
// Handshake bundle between the 8051 phase sequencer and its ROM, RAM,
// instruction decoder and ALU. The master modport is the sequencer side.
interface mcu_phase_sequencer_if;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [7:0]  instruction;
  logic [2:0]  run_phase;
  logic [2:0]  next_status;
  logic [2:0]  run_phase_init;
  logic [7:0]  addr_register_out;
  logic        ram_rd_req;
  logic        ram_wr_req;
  logic [7:0]  ram_addr;
  logic        ram_ack;
  logic [7:0]  operand;
  logic        alu_start;
  logic        alu_done;
  logic        err;
  logic [2:0]  dbg_state;

  modport master (
    output rom_req, rom_addr, instruction, run_phase, ram_rd_req, ram_wr_req,
           ram_addr, operand, alu_start, err, dbg_state,
    input  rom_ack, rom_data, next_status, run_phase_init, addr_register_out,
           ram_ack, alu_done
  );

  modport slave (
    input  rom_req, rom_addr, instruction, run_phase, ram_rd_req, ram_wr_req,
           ram_addr, operand, alu_start, err, dbg_state,
    output rom_ack, rom_data, next_status, run_phase_init, addr_register_out,
           ram_ack, alu_done
  );
endinterface

// File: rtl/mcu_phase_sequencer.sv
// 8051 control sequencer: fetches opcodes, holds the instruction register,
// walks the decoder-requested RAM read / ROM operand / ALU / RAM write phases
// through req/ack handshakes, and owns the PC and the run-phase counter.
// Optional build macro SEQ_ACK_TIMEOUT_EN: abandons any wait state after
// TIMEOUT_CYCLES cycles without an ack, pulses err and refetches the same PC.
module mcu_phase_sequencer #(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst,
  mcu_phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RAM_RD = 3'd3,
    S_ROM_RD = 3'd4,
    S_PROC   = 3'd5,
    S_RAM_WR = 3'd6
  } state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  operand_q, operand_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [2:0]  rp_q, rp_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        ack_seen;
  logic        timeout;

  // Select the completion strobe that belongs to the current wait state
  always_comb begin
    ack_seen = 1'b0;
    case (state_q)
      S_FETCH, S_ROM_RD: ack_seen = bus.rom_ack;
      S_RAM_RD, S_RAM_WR: ack_seen = bus.ram_ack;
      S_PROC:            ack_seen = bus.alu_done;
      default:           ack_seen = 1'b0;
    endcase
  end

`ifdef SEQ_ACK_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wcnt_q, wcnt_d;
  logic       in_wait;

  // Count ack-less wait cycles; any completion or non-wait state clears it
  always_comb begin
    in_wait = (state_q == S_FETCH) || (state_q == S_RAM_RD) || (state_q == S_RAM_WR) ||
              (state_q == S_ROM_RD) || (state_q == S_PROC);
    timeout = in_wait && !ack_seen && (wcnt_q == TO_LAST);
    wcnt_d  = '0;
    if (in_wait && !ack_seen && !timeout) wcnt_d = wcnt_q + 8'd1;
  end

  // Wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the register updates that accompany each transition
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    operand_d  = operand_q;
    ram_addr_d = ram_addr_q;
    rp_d       = rp_q;
    first_d    = first_q;
    err_d      = 1'b0;
    start_d    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (ack_seen) begin
          instr_d = bus.rom_data;
          pc_d    = pc_q + 16'd1;
          first_d = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // The phase count is loaded once per instruction, on its first decode
        if (first_q) begin
          rp_d    = bus.run_phase_init;
          first_d = 1'b0;
        end
        ram_addr_d = bus.addr_register_out;
        case (bus.next_status)
          3'b001: state_d = S_RAM_RD;
          3'b010: state_d = S_ROM_RD;
          3'b011: begin
            state_d = S_PROC;
            start_d = 1'b1;
          end
          3'b100: state_d = S_RAM_WR;
          3'b110, 3'b111: begin
            err_d   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_RAM_RD, S_RAM_WR, S_ROM_RD, S_PROC: begin
        if (ack_seen) begin
          if (state_q == S_ROM_RD) begin
            operand_d = bus.rom_data;
            pc_d      = pc_q + 16'd1;
          end
          // rp of 0 or 1 both mean this was the last pass of the phase
          if (rp_q <= 3'd1) begin
            rp_d    = 3'd0;
            state_d = S_FETCH;
          end else begin
            rp_d    = rp_q - 3'd1;
            state_d = S_DECODE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PC, instruction/operand/address latches, phase counter and pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= PC_RESET;
      instr_q    <= '0;
      operand_q  <= '0;
      ram_addr_q <= '0;
      rp_q       <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      operand_q  <= operand_d;
      ram_addr_q <= ram_addr_d;
      rp_q       <= rp_d;
      first_q    <= first_d;
      err_q      <= err_d;
      start_q    <= start_d;
    end
  end

  // Requests are decoded from the current state only
  always_comb begin
    bus.rom_req    = 1'b0;
    bus.ram_rd_req = 1'b0;
    bus.ram_wr_req = 1'b0;
    case (state_q)
      S_FETCH, S_ROM_RD: bus.rom_req    = 1'b1;
      S_RAM_RD:          bus.ram_rd_req = 1'b1;
      S_RAM_WR:          bus.ram_wr_req = 1'b1;
      default: ;
    endcase
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instruction = instr_q;
  assign bus.operand     = operand_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.run_phase   = rp_q;
  assign bus.alu_start   = start_q;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state_q;

endmodule
